// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first.
// RXD is resynchronised with two flops, the start bit is qualified at its
// centre, and each data/stop bit is then sampled one full bit period apart.
// A low stop bit raises a one-cycle FERR and parks the FSM in BREAK until
// the line returns high, so a held-low line never looks like a new start.
module uart_rx #(
    parameter int BAUD_DIV = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR,
    output logic       BUSY
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_sh;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_busy;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_sh_nxt;
    logic [7:0]    w_data_nxt;
    logic          w_valid_nxt;
    logic          w_ferr_nxt;
    logic          w_rx_s;
    logic          w_cnt_last;

    assign w_rx_s     = r_sync2;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous serial line; runs regardless of EN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and next-output logic for the receive FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        if (!EN) begin
            // Disable aborts any frame; the last good byte is kept.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_idx_nxt   = 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = CNT_ZERO;
                    w_idx_nxt = 3'd0;
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_nxt = CNT_ZERO;
                        // Still low at the start-bit centre: a real start, else a glitch.
                        if (!w_rx_s) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        w_cnt_nxt = CNT_ZERO;
                        w_sh_nxt  = {w_rx_s, r_sh[7:1]};
                        w_idx_nxt = r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (w_cnt_last) begin
                        w_cnt_nxt = CNT_ZERO;
                        if (w_rx_s) begin
                            w_data_nxt  = r_sh;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    w_cnt_nxt = CNT_ZERO;
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_BREAK;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_idx_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= 3'd0;
            r_sh    <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign DATA  = r_data;
    assign VALID = r_valid;
    assign FERR  = r_ferr;
    assign BUSY  = r_busy;

endmodule
